// File: rtl/machine_timer_pkg.sv
// Shared definitions for the CLINT-style machine timer.
// Register offsets, register selector enum and the address decoder.
`ifndef MACHINE_TIMER_ENABLE
`define MACHINE_TIMER_ENABLE
`endif

package machine_timer_pkg;

    localparam logic [4:0] MT_MSIP        = 5'h00;
    localparam logic [4:0] MT_MTIMECMP_LO = 5'h04;
    localparam logic [4:0] MT_MTIMECMP_HI = 5'h08;
    localparam logic [4:0] MT_MTIME_LO    = 5'h0C;
    localparam logic [4:0] MT_MTIME_HI    = 5'h10;
    localparam logic [4:0] MT_CTRL        = 5'h14;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_CTRL,
        REG_NONE
    } reg_sel_e;

    // Byte offset bits [1:0] are ignored by the caller.
    function automatic reg_sel_e decode(input logic [2:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == MT_MSIP[4:2])        sel = REG_MSIP;
        if (word == MT_MTIMECMP_LO[4:2]) sel = REG_CMP_LO;
        if (word == MT_MTIMECMP_HI[4:2]) sel = REG_CMP_HI;
        if (word == MT_MTIME_LO[4:2])    sel = REG_MTIME_LO;
        if (word == MT_MTIME_HI[4:2])    sel = REG_MTIME_HI;
        if (word == MT_CTRL[4:2])        sel = REG_CTRL;
        return sel;
    endfunction

endpackage

// File: rtl/machine_timer_prescaler.sv
// Tick divider for mtime: one tick every div+1 enabled cycles.
module machine_timer_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] count;

    assign tick = enable && (count == div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped machine timer (mtime/mtimecmp/msip) feeding the CSR unit.
import machine_timer_pkg::*;

module machine_timer #(
    parameter int          PRESCALER_WIDTH = 16,
    parameter logic [63:0] MTIMECMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_read_request,
    input  logic        bus_write_request,
    input  logic [4:0]  bus_address,
    input  logic [31:0] bus_write_data,
    output logic [31:0] bus_read_data,
    output logic        bus_ack,
    output logic        interruption_request_timer,
    output logic        interruption_request_software,
    output logic [63:0] mtime_value
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        enable;
    logic [PRESCALER_WIDTH-1:0] div;

    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;
    logic        msip_next;
    logic        enable_next;
    logic [PRESCALER_WIDTH-1:0] div_next;
    logic        ctrl_clear;
    logic [31:0] reg_data;
    logic        tick;
    logic        rd;
    logic        wr;
    reg_sel_e    sel;
    logic        unused_addr;

    assign unused_addr = ^bus_address[1:0];
    assign sel = decode(bus_address[4:2]);
    assign wr  = bus_write_request;
    assign rd  = bus_read_request && !bus_write_request;

    machine_timer_prescaler #(
        .WIDTH(PRESCALER_WIDTH)
    ) u_prescaler (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .clear(ctrl_clear),
        .div(div),
        .tick(tick)
    );

    always_comb begin
        reg_data = 32'd0;
        case (sel)
            REG_MSIP:     reg_data = {31'd0, msip};
            REG_CMP_LO:   reg_data = mtimecmp[31:0];
            REG_CMP_HI:   reg_data = mtimecmp[63:32];
            REG_MTIME_LO: reg_data = mtime[31:0];
            REG_MTIME_HI: reg_data = mtime[63:32];
            REG_CTRL:     reg_data = {{(31-PRESCALER_WIDTH){1'b0}}, div, enable};
            default:      reg_data = 32'd0;
        endcase
    end

    // An mtime half write overrides the increment, dropping that tick.
    always_comb begin
        mtime_next    = tick ? mtime + 64'd1 : mtime;
        mtimecmp_next = mtimecmp;
        msip_next     = msip;
        enable_next   = enable;
        div_next      = div;
        ctrl_clear    = 1'b0;
        if (wr) begin
            case (sel)
                REG_MSIP:     msip_next = bus_write_data[0];
                REG_CMP_LO:   mtimecmp_next[31:0] = bus_write_data;
                REG_CMP_HI:   mtimecmp_next[63:32] = bus_write_data;
                REG_MTIME_LO: mtime_next = {mtime[63:32], bus_write_data};
                REG_MTIME_HI: mtime_next = {bus_write_data, mtime[31:0]};
                REG_CTRL: begin
                    enable_next = bus_write_data[0];
                    div_next    = bus_write_data[PRESCALER_WIDTH:1];
                    ctrl_clear  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime                      <= 64'd0;
            mtimecmp                   <= MTIMECMP_RESET;
            msip                       <= 1'b0;
            enable                     <= 1'b1;
            div                        <= '0;
            bus_ack                    <= 1'b0;
            bus_read_data              <= 32'd0;
            interruption_request_timer <= 1'b0;
        end else begin
            mtime                      <= mtime_next;
            mtimecmp                   <= mtimecmp_next;
            msip                       <= msip_next;
            enable                     <= enable_next;
            div                        <= div_next;
            bus_ack                    <= rd || wr;
            bus_read_data              <= rd ? reg_data : 32'd0;
            interruption_request_timer <= (mtime >= mtimecmp);
        end
    end

    assign interruption_request_software = msip;
    assign mtime_value                   = mtime;

endmodule
